// File: rtl/lfsr_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lfsr_checker: self-synchronising XNOR-LFSR pattern checker with lock,    |
// | error pulse and saturating error count. LFSR_CHECKER_STATS_EN adds a     |
// | locked-word counter on o_Word_Count.                                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lfsr_checker #(
  parameter int NUM_BITS    = 5,
  parameter int LOCK_COUNT  = 8,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_BITS    = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear_Count,
  output logic                o_Locked,
  output logic                o_Error,
  output logic [ERR_BITS-1:0] o_Err_Count,
  output logic [31:0]         o_Word_Count
);

  if (NUM_BITS < 3 || NUM_BITS > 8 || LOCK_COUNT < 1 || LOSS_THRESH < 1) begin : g_bad_params
    $error("lfsr_checker: NUM_BITS must be 3..8, LOCK_COUNT and LOSS_THRESH >= 1");
  end

  // Tap masks, bit k-1 set for each 1-indexed tap k
  localparam logic [7:0] c_TAPS = (NUM_BITS == 3) ? 8'h06 :
                                  (NUM_BITS == 4) ? 8'h0C :
                                  (NUM_BITS == 5) ? 8'h14 :
                                  (NUM_BITS == 6) ? 8'h30 :
                                  (NUM_BITS == 7) ? 8'h60 : 8'hB8;
  localparam logic [NUM_BITS-1:0] c_TAP_MASK = c_TAPS[NUM_BITS-1:0];
  localparam logic [NUM_BITS-1:0] c_ONES     = '1;
  localparam int c_MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int c_MISS_W  = $clog2(LOSS_THRESH + 1);
  localparam logic [c_MATCH_W-1:0] c_LOCK_CNT = c_MATCH_W'(LOCK_COUNT);
  localparam logic [c_MISS_W-1:0]  c_LOSS_CNT = c_MISS_W'(LOSS_THRESH);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [NUM_BITS-1:0] step(input logic [NUM_BITS-1:0] x);
    return {x[NUM_BITS-2:0], ~^(x & c_TAP_MASK)};
  endfunction

  state_t                r_state;
  logic                  r_first;
  logic [NUM_BITS-1:0]   r_last_rx;
  logic [NUM_BITS-1:0]   r_expected;
  logic [c_MATCH_W-1:0]  r_match_cnt;
  logic [c_MISS_W-1:0]   r_miss_cnt;
  logic                  r_locked;
  logic                  r_error;
  logic [ERR_BITS-1:0]   r_err_count;

  logic [NUM_BITS-1:0]   w_step_last;
  logic [NUM_BITS-1:0]   w_step_exp;
  logic [NUM_BITS-1:0]   w_step_data;
  logic                  w_search_hit;
  logic [c_MATCH_W-1:0]  w_match_inc;
  logic [c_MISS_W-1:0]   w_miss_inc;
  logic [ERR_BITS-1:0]   w_err_inc;

  assign w_step_last  = step(r_last_rx);
  assign w_step_exp   = step(r_expected);
  assign w_step_data  = step(i_Data);
  assign w_search_hit = (i_Data == w_step_last) && (i_Data != c_ONES);
  assign w_match_inc  = r_match_cnt + 1'b1;
  assign w_miss_inc   = r_miss_cnt + 1'b1;
  assign w_err_inc    = (r_err_count == '1) ? r_err_count : r_err_count + 1'b1;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_state     <= SEARCH;
      r_first     <= 1'b1;
      r_last_rx   <= '0;
      r_expected  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_error <= 1'b0;
      if (i_Enable) begin
        case (r_state)
          SEARCH: begin
            r_last_rx <= i_Data;
            r_first   <= 1'b0;
            if (r_first) begin
              r_match_cnt <= '0;
            end else if (w_search_hit) begin
              r_match_cnt <= w_match_inc;
              if (w_match_inc == c_LOCK_CNT) begin
                r_state    <= LOCKED;
                r_locked   <= 1'b1;
                r_expected <= w_step_data;
                r_miss_cnt <= '0;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Prediction free-runs so a corrupted word cannot poison the next one
            r_expected <= w_step_exp;
            if (i_Data != r_expected) begin
              r_error     <= 1'b1;
              r_err_count <= w_err_inc;
              r_miss_cnt  <= w_miss_inc;
              if (w_miss_inc == c_LOSS_CNT) begin
                r_state     <= SEARCH;
                r_locked    <= 1'b0;
                r_match_cnt <= '0;
                r_last_rx   <= i_Data;
              end
            end else begin
              r_miss_cnt <= '0;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
      if (i_Clear_Count) begin
        r_err_count <= '0;
      end
    end
  end

  assign o_Locked    = r_locked;
  assign o_Error     = r_error;
  assign o_Err_Count = r_err_count;

`ifdef LFSR_CHECKER_STATS_EN
  logic [31:0] r_word_count;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L || i_Clear_Count) begin
      r_word_count <= '0;
    end else if (i_Enable && r_state == LOCKED && r_word_count != 32'hFFFF_FFFF) begin
      r_word_count <= r_word_count + 32'd1;
    end
  end

  assign o_Word_Count = r_word_count;
`else
  assign o_Word_Count = 32'd0;
`endif

endmodule
`default_nettype wire
